// File: rtl/nq_mem_pkg.sv
// nq_mem_pkg: shared state/owner encodings and widths for the APB memory access controller
package nq_mem_pkg;
  localparam int NQ_ADDR_W = 6;
  localparam int NQ_DATA_W = 16;
  localparam logic [NQ_DATA_W-1:0] ERR_RDATA = '0;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/mem_grant_sel.sv
// mem_grant_sel: data-over-fetch priority with a saturating streak that lets a starved fetch win
module mem_grant_sel
  import nq_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic grant_en,
  output logic owner,
  output logic grant
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] streak;
  logic          starved;
  always_comb begin
    starved = if_req && streak == SW'(STARVE_LIMIT);
    owner   = (dm_req && !starved) ? OWN_DM : OWN_IF;
    grant   = grant_en && (if_req || dm_req);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) streak <= '0;
    else if (grant_en)
      streak <= (!if_req || (grant && owner == OWN_IF)) ? '0 :
                (grant && !starved) ? streak + 1'b1 : streak;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: APB master sharing one memory between fetch and data ports,
// with pipeline stall, fetch starvation guard and pready timeout.
module mem_access_ctrl
  import nq_mem_pkg::*;
#(
  parameter int ADDR_W       = NQ_ADDR_W,
  parameter int DATA_W       = NQ_DATA_W,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT_CYC  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              err,
  output logic              stall,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  state_t          state;
  logic            own, err_q, gnt, gnt_own, timeout;
  logic [TW-1:0]   to_cnt;
  logic [DATA_W-1:0] cap;
  mem_grant_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req),
    .dm_req  (dm_req),
    .grant_en(state == IDLE),
    .owner   (gnt_own),
    .grant   (gnt)
  );
  always_comb begin
    psel    = state == SETUP || state == ACCESS;
    penable = state == ACCESS;
    if_done = state == RESP && own == OWN_IF;
    dm_done = state == RESP && own == OWN_DM;
    err     = state == RESP && err_q;
    stall   = (if_req && !if_done) || (dm_req && !dm_done);
    timeout = !pready && to_cnt == TW'(TIMEOUT_CYC - 1);
    cap     = pready ? prdata : DATA_W'(ERR_RDATA);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      own      <= OWN_IF;
      err_q    <= 1'b0;
      to_cnt   <= '0;
      paddr    <= '0;
      pwrite   <= 1'b0;
      pwdata   <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else case (state)
      IDLE: if (gnt) begin
        state  <= SETUP;
        own    <= gnt_own;
        paddr  <= gnt_own == OWN_DM ? dm_addr : if_addr;
        pwrite <= gnt_own == OWN_DM && dm_we;
        pwdata <= gnt_own == OWN_DM ? dm_wdata : '0;
      end
      SETUP: begin
        state  <= ACCESS;
        to_cnt <= '0;
      end
      ACCESS: if (pready || timeout) begin
        state <= RESP;
        err_q <= !pready || pslverr;
        if (own == OWN_DM) dm_rdata <= cap;
        else if_rdata <= cap;
      end else to_cnt <= to_cnt + 1'b1;
      default: state <= IDLE;
    endcase
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random transfers against a behavioural APB memory model
module tb_mem_access_ctrl;
  localparam int AW = 6;
  localparam int DW = 16;
  logic clk = 0, rst = 0;
  logic if_req = 0, dm_req = 0, dm_we = 0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, prdata = '0;
  logic pready = 0, pslverr = 0;
  logic if_done, dm_done, err, stall, psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, if_rdata, dm_rdata;
  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] slv_mem [64];
  logic [DW-1:0] ref_mem [64];
  int waits = 0, wcnt = 0;
  logic stuck = 0, serr = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .err(err), .stall(stall),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // APB slave: ready after 'waits' ACCESS cycles, noise on pready outside ACCESS
  always @(negedge clk) begin
    if (psel && penable) begin
      if (!stuck && wcnt >= waits) begin
        pready = 1; pslverr = serr; prdata = slv_mem[paddr];
        if (pwrite) slv_mem[paddr] = pwdata;
      end else begin
        pready = 0; pslverr = 1'($urandom % 2); prdata = 16'($urandom); wcnt++;
      end
    end else begin
      pready = 1'($urandom % 2); pslverr = 1'($urandom % 2); prdata = 16'($urandom); wcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for the port's done pulse; setup_c is the cycle SETUP is expected in
  task automatic wait_done(input string tag, input bit is_dm, input int setup_c, input int exp_acc,
                           input logic [AW-1:0] a, input bit we, input logic [DW-1:0] wd,
                           input logic [DW-1:0] exp_rd, input bit exp_err);
    int c = 0, acc = 0;
    bit seen = 0;
    logic [DW-1:0] other_rd = is_dm ? if_rdata : dm_rdata;
    while (!seen && c < 40) begin
      @(negedge clk);
      c++;
      seen = is_dm ? dm_done : if_done;
      if (c == setup_c) chk({tag, "_setup"}, 32'({psel, penable}), 32'b10);
      if (psel && penable) begin
        acc++;
        chk({tag, "_paddr"}, 32'(paddr), 32'(a));
        chk({tag, "_pwrite"}, 32'(pwrite), 32'(we));
        if (we) chk({tag, "_pwdata"}, 32'(pwdata), 32'(wd));
      end
      if (!seen) chk({tag, "_stall_hi"}, 32'(stall), 32'd1);
    end
    chk({tag, "_lat"}, 32'(c), 32'(setup_c + 1 + exp_acc));
    chk({tag, "_acc"}, 32'(acc), 32'(exp_acc));
    chk({tag, "_rdata"}, 32'(is_dm ? dm_rdata : if_rdata), 32'(exp_rd));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_other_done"}, 32'(is_dm ? if_done : dm_done), 32'd0);
    chk({tag, "_other_rd"}, 32'(is_dm ? if_rdata : dm_rdata), 32'(other_rd));
    chk({tag, "_stall_done"}, 32'(stall), 32'(is_dm ? if_req : dm_req));
  endtask

  task automatic xfer(input string tag, input bit is_dm, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input int w, input bit se, input bit st);
    logic [DW-1:0] exp_rd = st ? '0 : ref_mem[a];
    if (is_dm && we && !st) ref_mem[a] = wd;
    waits = w; serr = se; stuck = st;
    @(negedge clk);
    if (is_dm) begin dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = wd; end
    else begin if_req = 1; if_addr = a; end
    wait_done(tag, is_dm, 1, st ? 16 : w + 1, a, is_dm && we, wd, exp_rd, st || se);
    if_req = 0; dm_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, grants;
    for (int i = 0; i < 64; i++) begin slv_mem[i] = 16'($urandom); ref_mem[i] = slv_mem[i]; end
    // Reset with both requests pending
    if_req = 1; if_addr = 6'h11; dm_req = 1; dm_we = 0; dm_addr = 6'h22;
    repeat (3) @(negedge clk);
    chk("rst_apb", 32'({psel, penable, pwrite}), 32'd0);
    chk("rst_done", 32'({if_done, dm_done, err}), 32'd0);
    chk("rst_regs", 32'({paddr, pwdata}), 32'd0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 32'd0);
    chk("rst_stall", 32'(stall), 32'd1);
    rst = 1;
    wait_done("rst_dm", 1, 1, 1, 6'h22, 0, '0, ref_mem[6'h22], 0);
    dm_req = 0;
    wait_done("rst_if", 0, 2, 1, 6'h11, 0, '0, ref_mem[6'h11], 0);
    if_req = 0;
    // Directed transfers
    slv_mem[5] = 16'h1234; ref_mem[5] = 16'h1234;
    xfer("rd0", 1, 0, 6'h05, '0, 0, 0, 0);
    xfer("wr2", 1, 1, 6'h3F, 16'hBEEF, 2, 0, 0);
    xfer("rdback", 0, 0, 6'h3F, '0, 1, 0, 0);
    xfer("tmo_dm", 1, 0, 6'h07, '0, 0, 0, 1);
    xfer("tmo_if", 0, 0, 6'h08, '0, 0, 0, 1);
    xfer("slverr", 1, 0, 6'h09, '0, 1, 1, 0);
    // Starvation guard: four data grants, then fetch
    waits = 0; serr = 0; stuck = 0;
    @(negedge clk);
    if_req = 1; if_addr = 6'h01; dm_req = 1; dm_we = 0; dm_addr = 6'h02;
    grants = 0; c = 0;
    while (grants < 10 && c < 200) begin
      @(negedge clk);
      c++;
      if (dm_done || if_done) begin
        chk("starve_owner", 32'({if_done, dm_done}), grants % 5 == 4 ? 32'b10 : 32'b01);
        grants++;
      end
    end
    chk("starve_grants", 32'(grants), 32'd10);
    if_req = 0; dm_req = 0;
    // Reset during a fetch ACCESS
    stuck = 1;
    @(negedge clk);
    if_req = 1; if_addr = 6'h2A;
    c = 0;
    while (!(psel && penable) && c < 10) begin @(negedge clk); c++; end
    chk("mid_reach_acc", 32'(penable), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 0;
    #1 chk("mid_async", 32'({psel, penable, if_done, err}), 32'd0);
    @(negedge clk);
    chk("mid_nodone", 32'({if_done, err}), 32'd0);
    rst = 1; stuck = 0; waits = 0; serr = 0;
    wait_done("mid_restart", 0, 1, 1, 6'h2A, 0, '0, ref_mem[6'h2A], 0);
    if_req = 0;
    // Random transfers
    for (int i = 0; i < 40; i++) begin
      bit is_dm = 1'($urandom % 2);
      xfer("rnd", is_dm, is_dm && 1'($urandom % 2), 6'($urandom), 16'($urandom),
           int'($urandom % 4), $urandom % 8 == 0, $urandom % 16 == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
